// File: rtl/reorder_buffer_if.sv
//------------------------------------------------------------------------------
// Module   : reorder_buffer_if
// Purpose  : Decode, writeback, operand-read and commit bundle for reorder_buffer.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef REG_INDEX_SIZE
`define REG_INDEX_SIZE 5
`endif

interface reorder_buffer_if #(
   parameter int WORD_SIZE       = `WORD_SIZE,
   parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
   parameter int REG_INDEX_SIZE  = `REG_INDEX_SIZE
) ();
   logic                       require_rob_entry;
   logic                       is_store;
   logic [REG_INDEX_SIZE-1:0]  rd;
   logic [ROB_ENTRY_WIDTH-1:0] assigned_rob_id;
   logic                       full;

   logic [ROB_ENTRY_WIDTH-1:0] rs1_rob_entry;
   logic [ROB_ENTRY_WIDTH-1:0] rs2_rob_entry;
   logic [WORD_SIZE-1:0]       rob_s1_data;
   logic [WORD_SIZE-1:0]       rob_s2_data;
   logic                       rob_s1_valid;
   logic                       rob_s2_valid;

   logic [WORD_SIZE-1:0]       alu_wb_data;
   logic [ROB_ENTRY_WIDTH-1:0] alu_wb_rob_id;
   logic                       alu_wb_bypass_enable;
   logic [WORD_SIZE-1:0]       mem_wb_data;
   logic [ROB_ENTRY_WIDTH-1:0] mem_wb_rob_id;
   logic                       mem_wb_bypass_enable;
   logic [WORD_SIZE-1:0]       mul_wb_data;
   logic [ROB_ENTRY_WIDTH-1:0] mul_wb_rob_id;
   logic                       mul_wb_bypass_enable;

   logic                       commit;
   logic [REG_INDEX_SIZE-1:0]  commit_rd;
   logic [ROB_ENTRY_WIDTH-1:0] commit_rob_id;
   logic [WORD_SIZE-1:0]       commit_data;
   logic                       commit_is_store;

   modport master (
      output require_rob_entry, is_store, rd,
      output rs1_rob_entry, rs2_rob_entry,
      output alu_wb_data, alu_wb_rob_id, alu_wb_bypass_enable,
      output mem_wb_data, mem_wb_rob_id, mem_wb_bypass_enable,
      output mul_wb_data, mul_wb_rob_id, mul_wb_bypass_enable,
      input  assigned_rob_id, full,
      input  rob_s1_data, rob_s2_data, rob_s1_valid, rob_s2_valid,
      input  commit, commit_rd, commit_rob_id, commit_data, commit_is_store
   );

   modport slave (
      input  require_rob_entry, is_store, rd,
      input  rs1_rob_entry, rs2_rob_entry,
      input  alu_wb_data, alu_wb_rob_id, alu_wb_bypass_enable,
      input  mem_wb_data, mem_wb_rob_id, mem_wb_bypass_enable,
      input  mul_wb_data, mul_wb_rob_id, mul_wb_bypass_enable,
      output assigned_rob_id, full,
      output rob_s1_data, rob_s2_data, rob_s1_valid, rob_s2_valid,
      output commit, commit_rd, commit_rob_id, commit_data, commit_is_store
   );
endinterface

`default_nettype wire

// File: rtl/reorder_buffer.sv
//------------------------------------------------------------------------------
// Module   : reorder_buffer
// Purpose  : Circular in-order ROB: allocate, 3-port writeback, operand read,
//            in-order commit. Optional macro ROB_WB_FORWARD_EN forwards
//            same-cycle writebacks onto the operand read ports.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 3
`endif
`ifndef REG_INDEX_SIZE
`define REG_INDEX_SIZE 5
`endif

module reorder_buffer #(
   parameter int WORD_SIZE       = `WORD_SIZE,
   parameter int ROB_ENTRY_WIDTH = `ROB_ENTRY_WIDTH,
   parameter int REG_INDEX_SIZE  = `REG_INDEX_SIZE
) (
   input  wire logic       clk,
   input  wire logic       rst,
   reorder_buffer_if.slave bus
);

   localparam int c_ENTRIES = 2**ROB_ENTRY_WIDTH;
   localparam int c_CNT_W   = ROB_ENTRY_WIDTH + 1;
   localparam logic [c_CNT_W-1:0] c_FULL_COUNT = c_CNT_W'(c_ENTRIES);

   typedef struct packed {
      logic                 valid;
      logic [WORD_SIZE-1:0] data;
   } read_t;

   logic [c_ENTRIES-1:0]       r_valid;
   logic [c_ENTRIES-1:0]       r_ready;
   logic [c_ENTRIES-1:0]       r_store;
   logic [REG_INDEX_SIZE-1:0]  r_rd   [c_ENTRIES];
   logic [WORD_SIZE-1:0]       r_data [c_ENTRIES];
   logic [ROB_ENTRY_WIDTH-1:0] r_head;
   logic [ROB_ENTRY_WIDTH-1:0] r_tail;
   logic [c_CNT_W-1:0]         r_count;

   logic                       w_full;
   logic                       w_alloc;
   logic                       w_commit;
   logic [c_ENTRIES-1:0]       w_wb_en;
   logic [WORD_SIZE-1:0]       w_wb_data [c_ENTRIES];
   read_t                      w_s1;
   read_t                      w_s2;

   assign w_full   = (r_count == c_FULL_COUNT);
   assign w_alloc  = bus.require_rob_entry && !w_full;
   assign w_commit = r_valid[r_head] && r_ready[r_head];

   // Per-entry writeback select; later tests win, giving mul > mem > alu.
   always_comb begin
      for (int i = 0; i < c_ENTRIES; i++) begin
         w_wb_en[i]   = 1'b0;
         w_wb_data[i] = r_data[i];
         if (r_valid[i] && !r_ready[i]) begin
            if (bus.alu_wb_bypass_enable && (bus.alu_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
               w_wb_en[i]   = 1'b1;
               w_wb_data[i] = bus.alu_wb_data;
            end
            if (bus.mem_wb_bypass_enable && (bus.mem_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
               w_wb_en[i]   = 1'b1;
               w_wb_data[i] = bus.mem_wb_data;
            end
            if (bus.mul_wb_bypass_enable && (bus.mul_wb_rob_id == ROB_ENTRY_WIDTH'(i))) begin
               w_wb_en[i]   = 1'b1;
               w_wb_data[i] = bus.mul_wb_data;
            end
         end
      end
   end

   function automatic read_t read_port(input logic [ROB_ENTRY_WIDTH-1:0] id);
      read_t res;
      res.valid = r_valid[id] && r_ready[id];
      res.data  = r_data[id];
`ifdef ROB_WB_FORWARD_EN
      // w_wb_en already implies the entry is valid and still pending.
      if (w_wb_en[id]) begin
         res.valid = 1'b1;
         res.data  = w_wb_data[id];
      end
`endif
      return res;
   endfunction

   always_comb begin
      w_s1 = read_port(bus.rs1_rob_entry);
      w_s2 = read_port(bus.rs2_rob_entry);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= '0;
         r_ready <= '0;
         r_store <= '0;
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < c_ENTRIES; i++) begin
            r_rd[i]   <= '0;
            r_data[i] <= '0;
         end
      end else begin
         for (int i = 0; i < c_ENTRIES; i++) begin
            if (w_wb_en[i]) begin
               r_data[i]  <= w_wb_data[i];
               r_ready[i] <= 1'b1;
            end
         end
         // Head is ready and tail is free, so neither collides with writeback.
         if (w_commit) begin
            r_valid[r_head] <= 1'b0;
            r_head          <= r_head + 1'b1;
         end
         if (w_alloc) begin
            r_valid[r_tail] <= 1'b1;
            r_ready[r_tail] <= 1'b0;
            r_store[r_tail] <= bus.is_store;
            r_rd[r_tail]    <= bus.rd;
            r_tail          <= r_tail + 1'b1;
         end
         case ({w_alloc, w_commit})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign bus.full            = w_full;
   assign bus.assigned_rob_id = r_tail;
   assign bus.commit          = w_commit;
   assign bus.commit_rd       = r_rd[r_head];
   assign bus.commit_rob_id   = r_head;
   assign bus.commit_data     = r_data[r_head];
   assign bus.commit_is_store = r_store[r_head];
   assign bus.rob_s1_valid    = w_s1.valid;
   assign bus.rob_s1_data     = w_s1.data;
   assign bus.rob_s2_valid    = w_s2.valid;
   assign bus.rob_s2_data     = w_s2.data;

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer.sv
//------------------------------------------------------------------------------
// Module   : tb_reorder_buffer
// Purpose  : Directed and randomized checks of reorder_buffer against a
//            queue-based program-order model.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_reorder_buffer;

`ifdef ROB_WB_FORWARD_EN
   localparam bit c_FWD = 1'b1;
`else
   localparam bit c_FWD = 1'b0;
`endif

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   reorder_buffer_if #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(3), .REG_INDEX_SIZE(5)) bus ();

   reorder_buffer #(.WORD_SIZE(32), .ROB_ENTRY_WIDTH(3), .REG_INDEX_SIZE(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: ids of live entries in program order plus per-id payload.
   logic [2:0]  mq[$];
   logic [2:0]  mtail;
   bit          mrdy  [8];
   logic [31:0] mdata [8];
   logic [4:0]  mrd   [8];
   bit          mst   [8];

   task automatic clear_inputs();
      bus.require_rob_entry    = 1'b0;
      bus.is_store             = 1'b0;
      bus.rd                   = '0;
      bus.rs1_rob_entry        = '0;
      bus.rs2_rob_entry        = '0;
      bus.alu_wb_bypass_enable = 1'b0;
      bus.mem_wb_bypass_enable = 1'b0;
      bus.mul_wb_bypass_enable = 1'b0;
      bus.alu_wb_data = '0; bus.alu_wb_rob_id = '0;
      bus.mem_wb_data = '0; bus.mem_wb_rob_id = '0;
      bus.mul_wb_data = '0; bus.mul_wb_rob_id = '0;
   endtask

   // Writeback value (mul > mem > alu) aimed at id this cycle, if any.
   function automatic bit wb_hit(input logic [2:0] id, output logic [31:0] d);
      d = '0;
      if (bus.mul_wb_bypass_enable && bus.mul_wb_rob_id == id) begin d = bus.mul_wb_data; return 1'b1; end
      if (bus.mem_wb_bypass_enable && bus.mem_wb_rob_id == id) begin d = bus.mem_wb_data; return 1'b1; end
      if (bus.alu_wb_bypass_enable && bus.alu_wb_rob_id == id) begin d = bus.alu_wb_data; return 1'b1; end
      return 1'b0;
   endfunction

   function automatic bit is_live(input logic [2:0] id);
      foreach (mq[k]) if (mq[k] == id) return 1'b1;
      return 1'b0;
   endfunction

   function automatic void model_read(input logic [2:0] id, output logic v, output logic [31:0] d);
      logic [31:0] wd;
      v = is_live(id) && mrdy[id];
      d = mdata[id];
      if (c_FWD && is_live(id) && !mrdy[id] && wb_hit(id, wd)) begin
         v = 1'b1;
         d = wd;
      end
   endfunction

   // Advance model with the currently driven inputs, then clock the DUT.
   task automatic tick();
      logic [31:0] wd;
      bit          do_commit;
      bit          do_alloc;
      if (rst) begin
         mq.delete();
         mtail = '0;
         for (int i = 0; i < 8; i++) begin
            mrdy[i] = 0; mdata[i] = '0; mrd[i] = '0; mst[i] = 0;
         end
      end else begin
         do_commit = (mq.size() > 0) && mrdy[mq[0]];
         do_alloc  = bus.require_rob_entry && (mq.size() < 8);
         foreach (mq[k]) begin
            if (!mrdy[mq[k]] && wb_hit(mq[k], wd)) begin
               mrdy[mq[k]]  = 1;
               mdata[mq[k]] = wd;
            end
         end
         if (do_commit) begin
            mrdy[mq[0]] = 0;
            void'(mq.pop_front());
         end
         if (do_alloc) begin
            mq.push_back(mtail);
            mrdy[mtail] = 0;
            mrd[mtail]  = bus.rd;
            mst[mtail]  = bus.is_store;
            mtail       = mtail + 3'd1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic alloc(input logic [4:0] r, input bit st);
      bus.require_rob_entry = 1'b1;
      bus.rd                = r;
      bus.is_store          = st;
      tick();
      bus.require_rob_entry = 1'b0;
      bus.is_store          = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      n_checks += 9;
      if (bus.full !== 1'b0) begin n_errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
      if (bus.assigned_rob_id !== 3'd0) begin n_errors++; $display("FAIL reset_id: got %0d want 0", bus.assigned_rob_id); end
      if (bus.commit !== 1'b0) begin n_errors++; $display("FAIL reset_commit: got %b want 0", bus.commit); end
      if (bus.commit_is_store !== 1'b0) begin n_errors++; $display("FAIL reset_store: got %b want 0", bus.commit_is_store); end
      if (bus.rob_s1_valid !== 1'b0) begin n_errors++; $display("FAIL reset_s1v: got %b want 0", bus.rob_s1_valid); end
      if (bus.rob_s2_valid !== 1'b0) begin n_errors++; $display("FAIL reset_s2v: got %b want 0", bus.rob_s2_valid); end
      if (bus.commit_rd !== 5'd0) begin n_errors++; $display("FAIL reset_crd: got %0d want 0", bus.commit_rd); end
      if (bus.commit_data !== 32'd0) begin n_errors++; $display("FAIL reset_cdata: got %h want 0", bus.commit_data); end
      if (bus.commit_rob_id !== 3'd0) begin n_errors++; $display("FAIL reset_cid: got %0d want 0", bus.commit_rob_id); end
      tick();
   endtask

   task automatic test_fill();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         bus.require_rob_entry = 1'b1;
         bus.rd                = 5'(i + 1);
         @(negedge clk);
         n_checks += 2;
         if (bus.assigned_rob_id !== 3'(i)) begin n_errors++; $display("FAIL fill_id: got %0d want %0d", bus.assigned_rob_id, i); end
         if (bus.full !== 1'b0) begin n_errors++; $display("FAIL fill_notfull: got %b want 0", bus.full); end
         tick();
      end
      bus.rd = 5'd9;
      @(negedge clk);
      n_checks += 2;
      if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fill_full: got %b want 1", bus.full); end
      if (bus.assigned_rob_id !== 3'd0) begin n_errors++; $display("FAIL fill_wrap: got %0d want 0", bus.assigned_rob_id); end
      tick();
      bus.require_rob_entry = 1'b0;
      @(negedge clk);
      n_checks += 2;
      if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fill_ignored_full: got %b want 1", bus.full); end
      if (bus.assigned_rob_id !== 3'd0) begin n_errors++; $display("FAIL fill_tail_held: got %0d want 0", bus.assigned_rob_id); end
      tick();
   endtask

   task automatic test_single_commit();
      do_reset();
      alloc(5'd5, 1'b0);
      bus.alu_wb_bypass_enable = 1'b1;
      bus.alu_wb_rob_id        = 3'd0;
      bus.alu_wb_data          = 32'hDEADBEEF;
      @(negedge clk);
      n_checks++;
      if (bus.commit !== 1'b0) begin n_errors++; $display("FAIL single_early: got %b want 0", bus.commit); end
      tick();
      bus.alu_wb_bypass_enable = 1'b0;
      @(negedge clk);
      n_checks += 4;
      if (bus.commit !== 1'b1) begin n_errors++; $display("FAIL single_commit: got %b want 1", bus.commit); end
      if (bus.commit_rd !== 5'd5) begin n_errors++; $display("FAIL single_rd: got %0d want 5", bus.commit_rd); end
      if (bus.commit_rob_id !== 3'd0) begin n_errors++; $display("FAIL single_id: got %0d want 0", bus.commit_rob_id); end
      if (bus.commit_data !== 32'hDEADBEEF) begin n_errors++; $display("FAIL single_data: got %h want deadbeef", bus.commit_data); end
      tick();
      @(negedge clk);
      n_checks++;
      if (bus.commit !== 1'b0) begin n_errors++; $display("FAIL single_after: got %b want 0", bus.commit); end
      tick();
   endtask

   task automatic test_in_order();
      do_reset();
      alloc(5'd1, 1'b0);
      alloc(5'd2, 1'b0);
      bus.alu_wb_bypass_enable = 1'b1;
      bus.alu_wb_rob_id = 3'd1; bus.alu_wb_data = 32'd7;
      tick();
      bus.alu_wb_rob_id = 3'd0; bus.alu_wb_data = 32'd3;
      @(negedge clk);
      n_checks++;
      if (bus.commit !== 1'b0) begin n_errors++; $display("FAIL order_hold: got %b want 0", bus.commit); end
      tick();
      bus.alu_wb_bypass_enable = 1'b0;
      @(negedge clk);
      n_checks += 3;
      if (bus.commit !== 1'b1) begin n_errors++; $display("FAIL order_c0: got %b want 1", bus.commit); end
      if (bus.commit_rob_id !== 3'd0) begin n_errors++; $display("FAIL order_id0: got %0d want 0", bus.commit_rob_id); end
      if (bus.commit_data !== 32'd3) begin n_errors++; $display("FAIL order_d0: got %0d want 3", bus.commit_data); end
      tick();
      @(negedge clk);
      n_checks += 3;
      if (bus.commit !== 1'b1) begin n_errors++; $display("FAIL order_c1: got %b want 1", bus.commit); end
      if (bus.commit_rob_id !== 3'd1) begin n_errors++; $display("FAIL order_id1: got %0d want 1", bus.commit_rob_id); end
      if (bus.commit_data !== 32'd7) begin n_errors++; $display("FAIL order_d1: got %0d want 7", bus.commit_data); end
      tick();
   endtask

   task automatic test_full_commit_alloc();
      do_reset();
      for (int i = 0; i < 8; i++) alloc(5'(i + 10), 1'b0);
      bus.mem_wb_bypass_enable = 1'b1;
      bus.mem_wb_rob_id = 3'd0; bus.mem_wb_data = 32'h1234;
      tick();
      bus.mem_wb_bypass_enable = 1'b0;
      bus.require_rob_entry    = 1'b1;
      bus.rd                   = 5'd9;
      @(negedge clk);
      n_checks += 3;
      if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fca_full: got %b want 1", bus.full); end
      if (bus.commit !== 1'b1) begin n_errors++; $display("FAIL fca_commit: got %b want 1", bus.commit); end
      if (bus.commit_data !== 32'h1234) begin n_errors++; $display("FAIL fca_data: got %h want 1234", bus.commit_data); end
      tick();
      @(negedge clk);
      n_checks += 2;
      if (bus.full !== 1'b0) begin n_errors++; $display("FAIL fca_relieved: got %b want 0", bus.full); end
      if (bus.assigned_rob_id !== 3'd0) begin n_errors++; $display("FAIL fca_retry_id: got %0d want 0", bus.assigned_rob_id); end
      tick();
      bus.require_rob_entry = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.full !== 1'b1) begin n_errors++; $display("FAIL fca_refull: got %b want 1", bus.full); end
      tick();
   endtask

   task automatic test_store_and_read();
      do_reset();
      alloc(5'd3, 1'b1);
      alloc(5'd4, 1'b0);
      alloc(5'd6, 1'b0);
      bus.mem_wb_bypass_enable = 1'b1;
      bus.mem_wb_rob_id = 3'd0; bus.mem_wb_data = 32'h55;
      bus.mul_wb_bypass_enable = 1'b1;
      bus.mul_wb_rob_id = 3'd2; bus.mul_wb_data = 32'h10;
      bus.rs1_rob_entry = 3'd2;
      @(negedge clk);
      n_checks++;
      if (bus.rob_s1_valid !== c_FWD) begin n_errors++; $display("FAIL fwd_s1v: got %b want %b", bus.rob_s1_valid, c_FWD); end
      if (c_FWD) begin
         n_checks++;
         if (bus.rob_s1_data !== 32'h10) begin n_errors++; $display("FAIL fwd_s1d: got %h want 10", bus.rob_s1_data); end
      end
      tick();
      bus.mem_wb_bypass_enable = 1'b0;
      bus.mul_wb_bypass_enable = 1'b0;
      @(negedge clk);
      n_checks += 4;
      if (bus.commit !== 1'b1) begin n_errors++; $display("FAIL store_commit: got %b want 1", bus.commit); end
      if (bus.commit_is_store !== 1'b1) begin n_errors++; $display("FAIL store_flag: got %b want 1", bus.commit_is_store); end
      if (bus.rob_s1_valid !== 1'b1) begin n_errors++; $display("FAIL read_s1v: got %b want 1", bus.rob_s1_valid); end
      if (bus.rob_s1_data !== 32'h10) begin n_errors++; $display("FAIL read_s1d: got %h want 10", bus.rob_s1_data); end
      tick();
   endtask

   task automatic test_reset_mid();
      do_reset();
      alloc(5'd1, 1'b0);
      alloc(5'd2, 1'b0);
      alloc(5'd3, 1'b0);
      bus.alu_wb_bypass_enable = 1'b1;
      bus.alu_wb_rob_id = 3'd0; bus.alu_wb_data = 32'hA;
      bus.mul_wb_bypass_enable = 1'b1;
      bus.mul_wb_rob_id = 3'd1; bus.mul_wb_data = 32'hB;
      tick();
      clear_inputs();
      bus.rs1_rob_entry = 3'd0;
      bus.rs2_rob_entry = 3'd1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      n_checks += 5;
      if (bus.full !== 1'b0) begin n_errors++; $display("FAIL mid_full: got %b want 0", bus.full); end
      if (bus.commit !== 1'b0) begin n_errors++; $display("FAIL mid_commit: got %b want 0", bus.commit); end
      if (bus.rob_s1_valid !== 1'b0) begin n_errors++; $display("FAIL mid_s1v: got %b want 0", bus.rob_s1_valid); end
      if (bus.rob_s2_valid !== 1'b0) begin n_errors++; $display("FAIL mid_s2v: got %b want 0", bus.rob_s2_valid); end
      if (bus.assigned_rob_id !== 3'd0) begin n_errors++; $display("FAIL mid_id: got %0d want 0", bus.assigned_rob_id); end
      alloc(5'd7, 1'b0);
      @(negedge clk);
      n_checks++;
      if (bus.assigned_rob_id !== 3'd1) begin n_errors++; $display("FAIL mid_next_id: got %0d want 1", bus.assigned_rob_id); end
      tick();
   endtask

   function automatic logic [2:0] pick_id();
      if (mq.size() > 0 && $urandom_range(0, 3) != 0)
         return mq[$urandom_range(0, mq.size() - 1)];
      return 3'($urandom_range(0, 7));
   endfunction

   task automatic test_random();
      logic        ev;
      logic [31:0] ed;
      bit          ec;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         rst                      = ($urandom_range(0, 249) == 0);
         bus.require_rob_entry    = ($urandom_range(0, 9) < 6);
         bus.is_store             = ($urandom_range(0, 3) == 0);
         bus.rd                   = 5'($urandom_range(0, 31));
         bus.alu_wb_bypass_enable = $urandom_range(0, 1);
         bus.mem_wb_bypass_enable = $urandom_range(0, 1);
         bus.mul_wb_bypass_enable = $urandom_range(0, 1);
         bus.alu_wb_rob_id = pick_id(); bus.alu_wb_data = $urandom;
         bus.mem_wb_rob_id = pick_id(); bus.mem_wb_data = $urandom;
         bus.mul_wb_rob_id = pick_id(); bus.mul_wb_data = $urandom;
         bus.rs1_rob_entry = pick_id();
         bus.rs2_rob_entry = pick_id();
         @(negedge clk);
         ec = (mq.size() > 0) && mrdy[mq[0]];
         n_checks += 3;
         if (bus.full !== (mq.size() == 8)) begin n_errors++; $display("FAIL rnd_full c%0d: got %b want %b", cyc, bus.full, mq.size() == 8); end
         if (bus.assigned_rob_id !== mtail) begin n_errors++; $display("FAIL rnd_id c%0d: got %0d want %0d", cyc, bus.assigned_rob_id, mtail); end
         if (bus.commit !== ec) begin n_errors++; $display("FAIL rnd_commit c%0d: got %b want %b", cyc, bus.commit, ec); end
         if (ec) begin
            n_checks += 4;
            if (bus.commit_rob_id !== mq[0]) begin n_errors++; $display("FAIL rnd_cid c%0d: got %0d want %0d", cyc, bus.commit_rob_id, mq[0]); end
            if (bus.commit_rd !== mrd[mq[0]]) begin n_errors++; $display("FAIL rnd_crd c%0d: got %0d want %0d", cyc, bus.commit_rd, mrd[mq[0]]); end
            if (bus.commit_data !== mdata[mq[0]]) begin n_errors++; $display("FAIL rnd_cdata c%0d: got %h want %h", cyc, bus.commit_data, mdata[mq[0]]); end
            if (bus.commit_is_store !== mst[mq[0]]) begin n_errors++; $display("FAIL rnd_cst c%0d: got %b want %b", cyc, bus.commit_is_store, mst[mq[0]]); end
         end
         model_read(bus.rs1_rob_entry, ev, ed);
         n_checks++;
         if (bus.rob_s1_valid !== ev) begin n_errors++; $display("FAIL rnd_s1v c%0d: got %b want %b", cyc, bus.rob_s1_valid, ev); end
         if (ev) begin
            n_checks++;
            if (bus.rob_s1_data !== ed) begin n_errors++; $display("FAIL rnd_s1d c%0d: got %h want %h", cyc, bus.rob_s1_data, ed); end
         end
         model_read(bus.rs2_rob_entry, ev, ed);
         n_checks++;
         if (bus.rob_s2_valid !== ev) begin n_errors++; $display("FAIL rnd_s2v c%0d: got %b want %b", cyc, bus.rob_s2_valid, ev); end
         if (ev) begin
            n_checks++;
            if (bus.rob_s2_data !== ed) begin n_errors++; $display("FAIL rnd_s2d c%0d: got %h want %h", cyc, bus.rob_s2_data, ed); end
         end
         tick();
      end
      rst = 1'b0;
      clear_inputs();
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      mtail    = '0;
      clear_inputs();
      test_reset();
      test_fill();
      test_single_commit();
      test_in_order();
      test_full_commit_alloc();
      test_store_and_read();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
